// File: rtl/fpnew_pkg.sv
// fpnew_pkg: FP formats, status flags and the lane-collector state type.
// fp_width/num_lanes size the per-lane datapath of vector units.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } collect_state_e;

  function automatic int unsigned fp_width(
    input fp_format_e fmt
  );
    case (fmt)
      FP64:          return 64;
      FP16, FP16ALT: return 16;
      FP8:           return 8;
      default:       return 32;
    endcase
  endfunction

  function automatic int unsigned num_lanes(
    input int unsigned width,
    input fp_format_e  fmt,
    input logic        vec
  );
    int unsigned n;
    n = width / fp_width(fmt);
    if (!vec || n == 0) return 1;
    return n;
  endfunction

endpackage

// File: rtl/fpnew_lane_collector_if.sv
// Lane-side and result-side handshake bundle of fpnew_lane_collector.
// master: upstream lanes + downstream sink; slave: the collector.
interface fpnew_lane_collector_if
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat      = FP32,
  parameter int unsigned Width         = 64,
  parameter logic        EnableVectors = 1'b1,
  parameter type         TagType       = logic
);

  localparam int unsigned FP_WIDTH  =
    fp_width(FpFormat);
  localparam int unsigned NUM_LANES =
    num_lanes(Width, FpFormat, EnableVectors);

  logic [NUM_LANES-1:0][FP_WIDTH-1:0] lane_result_i;
  status_t [NUM_LANES-1:0] lane_status_i;
  logic [NUM_LANES-1:0]    lane_ext_bit_i;
  TagType                  lane_tag_i [NUM_LANES];
  logic [NUM_LANES-1:0]    lane_vectorial_i;
  logic [NUM_LANES-1:0]    lane_valid_i;
  logic [NUM_LANES-1:0]    lane_ready_o;
  logic                    flush_i;

  logic [Width-1:0]        result_o;
  status_t                 status_o;
  logic                    extension_bit_o;
  TagType                  tag_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  modport master (
    output lane_result_i,
    output lane_status_i,
    output lane_ext_bit_i,
    output lane_tag_i,
    output lane_vectorial_i,
    output lane_valid_i,
    input  lane_ready_o,
    output flush_i,
    input  result_o,
    input  status_o,
    input  extension_bit_o,
    input  tag_o,
    input  out_valid_o,
    output out_ready_i
  );

  modport slave (
    input  lane_result_i,
    input  lane_status_i,
    input  lane_ext_bit_i,
    input  lane_tag_i,
    input  lane_vectorial_i,
    input  lane_valid_i,
    output lane_ready_o,
    input  flush_i,
    output result_o,
    output status_o,
    output extension_bit_o,
    output tag_o,
    output out_valid_o,
    input  out_ready_i
  );

endinterface

// File: rtl/fpnew_lane_collector.sv
// Gathers per-lane FP results into one NaN-boxed/merged result word.
// Ports: clk_i, rst_ni (async low), bus (slave), busy_o,
// stall_cnt_o when FPNEW_COLLECTOR_STALL_CNT_EN is defined.
module fpnew_lane_collector
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat      = FP32,
  parameter int unsigned Width         = 64,
  parameter logic        EnableVectors = 1'b1,
  parameter type         TagType       = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fpnew_lane_collector_if.slave bus,
  output logic                 busy_o
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned FP_WIDTH  =
    fp_width(FpFormat);
  localparam int unsigned NUM_LANES =
    num_lanes(Width, FpFormat, EnableVectors);

  collect_state_e state_q, state_d;

  logic [NUM_LANES-1:0] captured_q, captured_d;
  logic [NUM_LANES-1:0] expected_q, expected_d;
  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] fire;
  logic [NUM_LANES-1:0] nz_lanes;
  logic [NUM_LANES-1:0] first_mask;
  logic [NUM_LANES-1:0] mask_eff;
  logic [NUM_LANES-1:0] capt_nxt;
  logic                 done;

  logic [FP_WIDTH-1:0] res_q [NUM_LANES];
  status_t             st_q  [NUM_LANES];
  logic                ext_q;
  TagType              tag_q;

  logic [Width-1:0] result;
  status_t          status;

  assign lane_ready =
    {NUM_LANES{(state_q != FULL) && !bus.flush_i}}
    & ~captured_q;
  assign bus.lane_ready_o = lane_ready;
  assign fire = bus.lane_valid_i & lane_ready;

  // A nonzero lane can only be part of a vector op.
  assign nz_lanes = ~NUM_LANES'(1);
  assign first_mask =
    (|(fire & (bus.lane_vectorial_i | nz_lanes)))
    ? '1 : NUM_LANES'(1);

  assign mask_eff =
    (state_q == IDLE) ? first_mask : expected_q;
  assign capt_nxt = captured_q | fire;
  assign done = (|capt_nxt) && (capt_nxt == mask_eff);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      captured_q <= '0;
      expected_q <= '0;
    end else begin
      state_q    <= state_d;
      captured_q <= captured_d;
      expected_q <= expected_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    captured_d = captured_q;
    expected_d = expected_q;
    unique case (state_q)
      IDLE: begin
        if (|fire) begin
          captured_d = capt_nxt;
          expected_d = first_mask;
          state_d    = done ? FULL : COLLECT;
        end
      end
      COLLECT: begin
        captured_d = capt_nxt;
        if (done) state_d = FULL;
      end
      FULL: begin
        if (bus.out_ready_i) begin
          state_d    = IDLE;
          captured_d = '0;
          expected_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        captured_d = '0;
        expected_d = '0;
      end
    endcase
    // Kill wins over any capture or output handshake.
    if (bus.flush_i) begin
      state_d    = IDLE;
      captured_d = '0;
      expected_d = '0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [FP_WIDTH-1:0] res_r;
    status_t             st_r;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        res_r <= '0;
        st_r  <= '0;
      end else if (fire[l]) begin
        res_r <= bus.lane_result_i[l];
        st_r  <= bus.lane_status_i[l];
      end
    end

    assign res_q[l] = res_r;
    assign st_q[l]  = st_r;

    if (l == 0) begin : g_side
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ext_q <= 1'b0;
          tag_q <= '0;
        end else if (fire[0]) begin
          ext_q <= bus.lane_ext_bit_i[0];
          tag_q <= bus.lane_tag_i[0];
        end
      end
    end
  end

  // Lanes outside the op and unused top bits carry the
  // lane 0 extension bit (NaN-box or sign fill).
  always_comb begin
    result = {Width{ext_q}};
    status = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (expected_q[l]) begin
        result[l*FP_WIDTH +: FP_WIDTH] = res_q[l];
        status = status_t'(status | st_q[l]);
      end
    end
  end

  assign bus.result_o        = result;
  assign bus.status_o        = status;
  assign bus.extension_bit_o = ext_q;
  assign bus.tag_o           = tag_q;
  assign bus.out_valid_o     = (state_q == FULL);
  assign busy_o              = (state_q != IDLE);

`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if ((state_q == FULL) && !bus.out_ready_i
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_fpnew_lane_collector.sv
// Self-checking bench for fpnew_lane_collector (FP32, 64-bit, 2 lanes).
// Directed scenarios plus randomized transactions vs a txn-level model.
module tb_fpnew_lane_collector;

  localparam int unsigned W  = 64;
  localparam int unsigned FW = 32;
  localparam int unsigned NL = 2;

  typedef fpnew_pkg::status_t st_t;

  typedef struct packed {
    logic                   vec;
    logic [NL-1:0][FW-1:0]  res;
    st_t  [NL-1:0]          st;
    logic                   ext;
    logic                   tag;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpnew_lane_collector_if #(
    .FpFormat      (fpnew_pkg::FP32),
    .Width         (W),
    .EnableVectors (1'b1),
    .TagType       (logic)
  ) bus ();

  fpnew_lane_collector #(
    .FpFormat      (fpnew_pkg::FP32),
    .Width         (W),
    .EnableVectors (1'b1),
    .TagType       (logic)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
    .busy_o (busy)
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  // Reference model: what the collected word must look like.
  function automatic logic [W-1:0] exp_result(input txn_t t);
    logic [FW-1:0] hi;
    hi = t.vec ? t.res[1] : {FW{t.ext}};
    return {hi, t.res[0]};
  endfunction

  function automatic st_t exp_status(input txn_t t);
    if (t.vec) return st_t'(t.st[0] | t.st[1]);
    return t.st[0];
  endfunction

  function automatic txn_t rand_txn(input logic vec);
    txn_t t;
    t.vec    = vec;
    t.res[0] = $urandom;
    t.res[1] = $urandom;
    t.st[0]  = st_t'(5'($urandom));
    t.st[1]  = st_t'(5'($urandom));
    t.ext    = 1'($urandom);
    t.tag    = 1'($urandom);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.lane_valid_i     = '0;
    bus.lane_vectorial_i = '0;
    bus.lane_result_i    = '0;
    bus.lane_status_i    = '0;
    bus.lane_ext_bit_i   = '0;
    bus.lane_tag_i[0]    = 1'b0;
    bus.lane_tag_i[1]    = 1'b0;
    bus.flush_i          = 1'b0;
    bus.out_ready_i      = 1'b0;
  endtask

  task automatic offer(input int l, input txn_t t);
    bus.lane_valid_i[l]     = 1'b1;
    bus.lane_result_i[l]    = t.res[l];
    bus.lane_status_i[l]    = t.st[l];
    bus.lane_vectorial_i[l] = t.vec;
    bus.lane_ext_bit_i[l]   = (l == 0) ? t.ext : 1'($urandom);
    bus.lane_tag_i[l]       = (l == 0) ? t.tag : 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    n_chk++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", bus.out_valid_o);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_chk++;
    if (bus.lane_ready_o !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 11", bus.lane_ready_o);
    end
    n_chk++;
    if (bus.result_o !== 64'h0 || bus.status_o !== st_t'(0)) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h want 0/0",
               bus.result_o, bus.status_o);
    end
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stall got %0d want 0", stall_cnt);
    end
`endif
  endtask

  task automatic test_scalar();
    txn_t t;
    t = rand_txn(1'b0);
    t.res[0] = 32'h3F80_0000;
    t.ext    = 1'b1;
    t.tag    = 1'b1;
    offer(0, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL scalar_valid got %b/%b want 1/1",
               bus.out_valid_o, busy);
    end
    n_chk++;
    if (bus.result_o !== 64'hFFFF_FFFF_3F80_0000) begin
      n_fail++;
      $display("FAIL scalar_result got %h want ffffffff3f800000",
               bus.result_o);
    end
    n_chk++;
    if (bus.extension_bit_o !== 1'b1 || bus.tag_o !== 1'b1) begin
      n_fail++;
      $display("FAIL scalar_ext_tag got %b/%b want 1/1",
               bus.extension_bit_o, bus.tag_o);
    end
    n_chk++;
    if (bus.lane_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL scalar_full_ready got %b want 00",
               bus.lane_ready_o);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    n_chk++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL scalar_drain got %b/%b want 0/0",
               bus.out_valid_o, busy);
    end
  endtask

  task automatic test_vector_ooo();
    txn_t t;
    t = rand_txn(1'b1);
    t.res[1] = 32'h4000_0000;
    t.res[0] = 32'h3F80_0000;
    offer(1, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.lane_ready_o !== 2'b01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_collect got ready=%b busy=%b want 01/1",
               bus.lane_ready_o, busy);
    end
    for (int c = 1; c <= 3; c++) begin
      n_chk++;
      if (bus.out_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL vec_early_valid t%0d got 1 want 0", c);
      end
      if (c < 3) tick();
    end
    offer(0, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b1
        || bus.result_o !== 64'h4000_0000_3F80_0000) begin
      n_fail++;
      $display("FAIL vec_result got v=%b %h want 1 400000003f800000",
               bus.out_valid_o, bus.result_o);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_status();
    txn_t t;
    st_t  nx, of;
    nx = '0;
    nx.NX = 1'b1;
    of = '0;
    of.OF = 1'b1;
    t = rand_txn(1'b1);
    t.st[0] = nx;
    t.st[1] = of;
    offer(0, t);
    offer(1, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b1 || bus.status_o !== (nx | of)) begin
      n_fail++;
      $display("FAIL status_vec got %b want %b",
               bus.status_o, nx | of);
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    t = rand_txn(1'b0);
    t.st[0] = nx;
    t.ext   = 1'b0;
    offer(0, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.status_o !== nx) begin
      n_fail++;
      $display("FAIL status_scalar got %b want %b", bus.status_o, nx);
    end
    n_chk++;
    if (bus.result_o !== {32'h0, t.res[0]}) begin
      n_fail++;
      $display("FAIL status_scalar_box got %h want %h",
               bus.result_o, {32'h0, t.res[0]});
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    txn_t a, b;
    a = rand_txn(1'b1);
    b = rand_txn(1'b1);
    offer(0, a);
    tick();
    idle_inputs();
    n_chk++;
    if (busy !== 1'b1 || bus.lane_ready_o !== 2'b10) begin
      n_fail++;
      $display("FAIL flush_pre got busy=%b ready=%b want 1/10",
               busy, bus.lane_ready_o);
    end
    bus.flush_i = 1'b1;
    #1;
    n_chk++;
    if (bus.lane_ready_o !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_ready got %b want 00", bus.lane_ready_o);
    end
    tick();
    bus.flush_i = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || bus.out_valid_o !== 1'b0
        || bus.lane_ready_o !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_idle got busy=%b v=%b ready=%b want 0/0/11",
               busy, bus.out_valid_o, bus.lane_ready_o);
    end
    offer(1, b);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_discard got v=%b busy=%b want 0/1",
               bus.out_valid_o, busy);
    end
    offer(0, b);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b1
        || bus.result_o !== exp_result(b)) begin
      n_fail++;
      $display("FAIL flush_after got v=%b %h want 1 %h",
               bus.out_valid_o, bus.result_o, exp_result(b));
    end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      txn_t t;
      int off0, off1, last, hold;
      t    = rand_txn(1'($urandom));
      off0 = $urandom_range(0, 3);
      off1 = t.vec ? $urandom_range(0, 3) : -1;
      last = (off1 > off0) ? off1 : off0;
      for (int c = 0; c <= last; c++) begin
        if (c == off0) offer(0, t);
        if (c == off1) offer(1, t);
        tick();
        idle_inputs();
        if (c < last) begin
          n_chk++;
          if (bus.out_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_early n=%0d c=%0d got 1 want 0", n, c);
          end
        end
      end
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        n_chk++;
        if (bus.out_valid_o !== 1'b1
            || bus.result_o !== exp_result(t)
            || bus.status_o !== exp_status(t)
            || bus.extension_bit_o !== t.ext
            || bus.tag_o !== t.tag) begin
          n_fail++;
          $display("FAIL rand_out n=%0d h=%0d got v=%b %h %b %b %b want 1 %h %b %b %b",
                   n, h, bus.out_valid_o, bus.result_o, bus.status_o,
                   bus.extension_bit_o, bus.tag_o, exp_result(t),
                   exp_status(t), t.ext, t.tag);
        end
        if (h < hold) tick();
      end
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      n_chk++;
      if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_drain n=%0d got v=%b busy=%b want 0/0",
                 n, bus.out_valid_o, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    txn_t t;
    do_reset();
    t = rand_txn(1'b1);
    offer(0, t);
    offer(1, t);
    tick();
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_chk++;
      if (bus.out_valid_o !== 1'b1
          || bus.result_o !== exp_result(t)
          || bus.status_o !== exp_status(t)
          || bus.lane_ready_o !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_stable c=%0d got v=%b %h %b r=%b want 1 %h %b 00",
                 c, bus.out_valid_o, bus.result_o, bus.status_o,
                 bus.lane_ready_o, exp_result(t), exp_status(t));
      end
    end
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 32'd5) begin
      n_fail++;
      $display("FAIL bp_stall got %0d want 5", stall_cnt);
    end
`endif
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    n_chk++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_flush got v=%b busy=%b want 0/0",
               bus.out_valid_o, busy);
    end
    tick();
`ifdef FPNEW_COLLECTOR_STALL_CNT_EN
    n_chk++;
    if (stall_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL bp_stall_keep got %0d want 6", stall_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_full();
    txn_t t;
    t = rand_txn(1'b0);
    offer(0, t);
    tick();
    idle_inputs();
    n_chk++;
    if (bus.out_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre got v=%b want 1", bus.out_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.out_valid_o !== 1'b0 || busy !== 1'b0
        || bus.lane_ready_o !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_async got v=%b busy=%b r=%b want 0/0/11",
               bus.out_valid_o, busy, bus.lane_ready_o);
    end
    #2;
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (bus.out_valid_o !== 1'b0 || bus.result_o !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_cleared got v=%b %h want 0 0",
               bus.out_valid_o, bus.result_o);
    end
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_scalar();
    test_vector_ooo();
    test_status();
    test_flush();
    test_random();
    test_backpressure();
    test_reset_mid_full();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpnew_lane_collector.md
FPNEW_LANE_COLLECTOR -- requirements
Module: fpnew_lane_collector

Interface
REQ-001 SHALL have parameter FpFormat, default fpnew_pkg::FP32, lane floating-point format.
REQ-002 SHALL have parameter Width, default 64, full result width in bits.
REQ-003 SHALL have parameter EnableVectors, default 1'b1; when 0, only lane 0 exists.
REQ-004 SHALL have parameter TagType, default logic, type of the operation tag.
REQ-005 SHALL derive FP_WIDTH = fpnew_pkg::fp_width(FpFormat) and NUM_LANES = fpnew_pkg::num_lanes(Width, FpFormat, EnableVectors).
REQ-006 SHALL have port clk_i  in  1  clock; the block uses one clock.
REQ-007 SHALL have port rst_ni  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port lane_result_i  in  NUM_LANES x FP_WIDTH  per-lane results.
REQ-009 SHALL have port lane_status_i  in  NUM_LANES x fpnew_pkg::status_t  per-lane flags.
REQ-010 SHALL have port lane_ext_bit_i  in  NUM_LANES  per-lane extension bit.
REQ-011 SHALL have port lane_tag_i  in  NUM_LANES x TagType  per-lane tag.
REQ-012 SHALL have port lane_vectorial_i  in  NUM_LANES  per-lane flag marking the operation as vectorial.
REQ-013 SHALL have ports lane_valid_i  in  NUM_LANES and lane_ready_o  out  NUM_LANES, the per-lane handshake.
REQ-014 SHALL have port flush_i  in  1  synchronous kill of collected data.
REQ-015 SHALL have ports result_o  out  Width, status_o  out  status_t, extension_bit_o  out  1 and tag_o  out  TagType, the collected output.
REQ-016 SHALL have ports out_valid_o  out  1 and out_ready_i  in  1, the downstream handshake.
REQ-017 SHALL have port busy_o  out  1, high while any data is held.

Function
REQ-018 SHALL implement states IDLE, COLLECT and FULL.
REQ-019 SHALL capture lane l on lane_valid_i[l] & lane_ready_o[l] into a per-lane register and set captured[l].
REQ-020 SHALL drive lane_ready_o[l] = (state != FULL) & ~captured[l] & ~flush_i.
REQ-021 In IDLE, the first capture SHALL latch the expected mask: all lanes if that lane's vectorial flag is 1 or the capturing lane is nonzero, else lane 0 only.
REQ-022 For multiple captures in the same IDLE cycle, the expected mask SHALL be all lanes if any captured lane's vectorial flag is 1.
REQ-023 The state SHALL move IDLE->COLLECT on the first capture, and IDLE/COLLECT->FULL in the cycle when captured equals the expected mask (IDLE->FULL directly is allowed).
REQ-024 out_valid_o SHALL equal (state == FULL), giving a latency of 1 cycle from the last lane capture.
REQ-025 On out_valid_o & out_ready_i, the block SHALL go to IDLE and clear captured and the expected mask; lanes are not ready in that cycle.
REQ-026 result_o SHALL hold expected lanes' captured values; unexpected lanes and bits [Width-1:NUM_LANES*FP_WIDTH] SHALL be filled with the lane 0 extension bit (NaN-box/sign-extend).
REQ-027 status_o SHALL be the OR of captured status over expected lanes only.
REQ-028 extension_bit_o and tag_o SHALL come from captured lane 0.
REQ-029 Outputs SHALL be stable while out_valid_o & ~out_ready_i.
REQ-030 flush_i SHALL force IDLE next cycle and discard all captures, with priority over captures and output handshake.
REQ-031 busy_o SHALL equal (state != IDLE).

Reset
REQ-032 On rst_ni low, the block SHALL enter IDLE with captured, expected mask and data registers at 0, and out_valid_o=0, busy_o=0, lane_ready_o all 1 after reset release.

Configuration
REQ-033 With FPNEW_COLLECTOR_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o [31:0], counting cycles with out_valid_o & ~out_ready_i, saturating at all-ones, reset to 0, and not cleared by flush.
REQ-034 Without FPNEW_COLLECTOR_STALL_CNT_EN, the port and counter SHALL be absent.

Structure
REQ-035 The state enum SHALL live in fpnew_pkg as collect_state_e; fp_width, num_lanes and status_t SHALL be reused from fpnew_pkg.
REQ-036 The block SHALL have no sub-modules; the per-lane capture register SHALL be a generate loop.

Verification
REQ-037 Scalar (FP32, Width=64): lane0 valid, vectorial=0, result 0x3F800000 -> out_valid_o after 1 cycle, result_o=0xFFFFFFFF_3F800000 with ext=1, lane 1 never awaited.
REQ-038 Vector out of order: lane1 0x40000000 at t0, lane0 0x3F800000 at t3 -> out_valid_o at t4, result_o=0x40000000_3F800000.
REQ-039 Status merge: lane0 NX, lane1 OF -> status_o has NX|OF; scalar op with lane1 status ignored.
REQ-040 Backpressure: out_ready_i low 5 cycles in FULL -> outputs stable, lane_ready_o=0, stall_cnt_o=5 (macro on).
REQ-041 Flush: flush_i with lane0 captured in COLLECT -> IDLE next cycle, busy_o=0, no out_valid_o.
REQ-042 Reset mid-FULL: rst_ni low asynchronously -> out_valid_o=0 immediately, captured cleared.
